y_enhance_core: RTL and testbench

Y_ENHANCE_CORE -- requirements
Module: y_enhance_core

---
 rtl/y_enhance_pkg.sv | 6 +
 rtl/y_enhance_if.sv | 25 ++
 rtl/y_enhance_calc.sv | 26 ++
 rtl/y_enhance_core.sv | 81 ++++++++
 tb/tb_y_enhance_core.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/y_enhance_pkg.sv
// y_enhance_pkg: shared width default, FSM encoding and rounding constant
package y_enhance_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int RND = 2;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
endpackage

// File: rtl/y_enhance_if.sv
// y_enhance_if: pixel stream in/out handshake bundle
interface y_enhance_if
  import y_enhance_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_y;
  logic             in_sol;
  logic             in_eol;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_y;
  logic             out_sol;
  logic             out_eol;
  modport slave (
    input  in_valid, in_y, in_sol, in_eol, out_ready,
    output in_ready, out_valid, out_y, out_sol, out_eol
  );
  modport master (
    output in_valid, in_y, in_sol, in_eol, out_ready,
    input  in_ready, out_valid, out_y, out_sol, out_eol
  );
endinterface

// File: rtl/y_enhance_calc.sv
// y_enhance_calc: 3-tap unsharp enhancement of one luma sample
module y_enhance_calc
  import y_enhance_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] i_prev,
  input  logic [PIX_W-1:0] i_cur,
  input  logic [PIX_W-1:0] i_next,
  input  logic [7:0]       i_th,
  input  logic             i_bypass,
  output logic [PIX_W-1:0] o_y
);
  logic        [PIX_W+1:0] w_avg;
  logic        [PIX_W+1:0] w_mag;
  logic signed [PIX_W+1:0] w_diff;
  logic signed [PIX_W+1:0] w_sum;
  assign w_avg  = ({2'b0, i_prev} + {1'b0, i_cur, 1'b0} + {2'b0, i_next} + (PIX_W+2)'(RND)) >> 2;
  assign w_diff = $signed({2'b0, i_cur}) - $signed(w_avg);
  assign w_mag  = w_diff[PIX_W+1] ? $unsigned(-w_diff) : $unsigned(w_diff);
  // cur + diff spans -(2^PIX_W-1)..2*(2^PIX_W-1): sign bit means underflow, bit PIX_W overflow
  assign w_sum  = $signed({2'b0, i_cur}) + w_diff;
  assign o_y    = (i_bypass || (32'(w_mag) <= 32'(i_th))) ? i_cur :
                  w_sum[PIX_W+1] ? '0 :
                  w_sum[PIX_W]   ? '1 : w_sum[PIX_W-1:0];
endmodule

// File: rtl/y_enhance_core.sv
// y_enhance_core: line-aware luma sharpening with a 3-pixel window and registered output
module y_enhance_core
  import y_enhance_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bypass,
  input  logic [7:0] diff_threshold,
  y_enhance_if.slave s
);
  state_t           r_state;
  logic [PIX_W-1:0] r_prev;
  logic [PIX_W-1:0] r_cur;
  logic             r_first;
  logic             r_byp;
  logic [7:0]       r_th;
  logic             r_ov;
  logic [PIX_W-1:0] r_oy;
  logic             r_os;
  logic             r_oe;
  logic             w_free;
  logic             w_acc;
  logic             w_emit;
  logic [PIX_W-1:0] w_next;
  logic [PIX_W-1:0] w_out;
  assign w_free      = !r_ov || s.out_ready;
  assign s.in_ready  = (r_state != FLUSH) && w_free;
  assign w_acc       = s.in_valid && s.in_ready;
  assign w_emit      = (r_state == FLUSH && w_free) || (w_acc && (r_state == FILL || r_state == RUN));
  // the last pixel of a line reuses itself as its right neighbour
  assign w_next      = (r_state == FLUSH) ? r_cur : s.in_y;
  assign s.out_valid = r_ov;
  assign s.out_y     = r_oy;
  assign s.out_sol   = r_os;
  assign s.out_eol   = r_oe;
  y_enhance_calc #(.PIX_W(PIX_W)) u_calc (
    .i_prev  (r_prev),
    .i_cur   (r_cur),
    .i_next  (w_next),
    .i_th    (r_th),
    .i_bypass(r_byp),
    .o_y     (w_out)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_cur   <= '0;
      r_first <= 1'b0;
      r_byp   <= 1'b0;
      r_th    <= '0;
      r_ov    <= 1'b0;
      r_oy    <= '0;
      r_os    <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      if (w_emit) begin
        r_ov <= 1'b1;
        r_oy <= w_out;
        r_os <= r_first;
        r_oe <= r_state == FLUSH;
      end else if (s.out_ready) begin
        r_ov <= 1'b0;
      end
      if (w_acc) begin
        r_prev  <= (r_state == IDLE) ? s.in_y : r_cur;
        r_cur   <= s.in_y;
        r_first <= r_state == IDLE;
        r_state <= s.in_eol ? FLUSH : (r_state == IDLE) ? FILL : RUN;
        if (r_state == IDLE) begin
          r_byp <= bypass;
          r_th  <= diff_threshold;
        end
      end else if (r_state == FLUSH && w_free) begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_y_enhance_core.sv
// tb_y_enhance_core: directed line vectors plus stall, register-latch and reset sequences
module tb_y_enhance_core;
  typedef struct {
    logic            byp;
    logic [7:0]      th;
    int              n;
    logic [0:7][7:0] px;
    logic [0:7][7:0] ex;
  } vec_t;
  typedef struct {
    logic [7:0] y;
    logic       sol;
    logic       eol;
  } ob_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bypass = 1'b0;
  logic [7:0] th = 8'd0;
  int         nchk = 0;
  int         nfail = 0;
  ob_t        q[$];
  vec_t       vecs[7];
  y_enhance_if #(.PIX_W(8)) b();
  y_enhance_core #(.PIX_W(8)) dut (
    .clk           (clk),
    .rst           (rst_n),
    .bypass        (bypass),
    .diff_threshold(th),
    .s             (b)
  );
  always #5 clk = ~clk;
  always begin
    @(negedge clk);
    #4;
    if (rst_n && b.out_valid && b.out_ready) q.push_back('{b.out_y, b.out_sol, b.out_eol});
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic send_px(input logic [7:0] y, input logic sol, input logic eol);
    int t = 0;
    @(negedge clk);
    b.in_valid = 1'b1;
    b.in_y = y;
    b.in_sol = sol;
    b.in_eol = eol;
    #4;
    while (!b.in_ready && t < 50) begin
      @(negedge clk);
      #4;
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
  endtask
  task automatic send_line(input int n, input logic [0:7][7:0] px);
    for (int k = 0; k < n; k++) send_px(px[k], k == 0, k == n - 1);
  endtask
  task automatic check_line(input string nm, input int n, input logic [0:7][7:0] ex);
    int t = 0;
    while (q.size() < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk($sformatf("%s_count", nm), q.size(), n);
    for (int k = 0; k < n && k < q.size(); k++) begin
      chk($sformatf("%s_px%0d_y", nm, k), q[k].y, ex[k]);
      chk($sformatf("%s_px%0d_sol", nm, k), q[k].sol, k == 0);
      chk($sformatf("%s_px%0d_eol", nm, k), q[k].eol, k == n - 1);
    end
    q.delete();
  endtask
  initial begin
    vecs[0] = '{1'b1, 8'd0,   3, {8'd10, 8'd200, 8'd10, 40'd0}, {8'd10, 8'd200, 8'd10, 40'd0}};
    vecs[1] = '{1'b0, 8'd10,  3, {8'd100, 8'd140, 8'd100, 40'd0}, {8'd100, 8'd160, 8'd100, 40'd0}};
    vecs[2] = '{1'b0, 8'd0,   3, {8'd0, 8'd250, 8'd0, 40'd0}, {8'd0, 8'd255, 8'd0, 40'd0}};
    vecs[3] = '{1'b0, 8'd0,   1, {8'd77, 56'd0}, {8'd77, 56'd0}};
    vecs[4] = '{1'b0, 8'd4,   4, {8'd20, 8'd40, 8'd60, 8'd80, 32'd0}, {8'd15, 8'd40, 8'd60, 8'd85, 32'd0}};
    vecs[5] = '{1'b0, 8'd20,  2, {8'd0, 8'd100, 48'd0}, {8'd0, 8'd125, 48'd0}};
    vecs[6] = '{1'b0, 8'd255, 3, {8'd0, 8'd250, 8'd0, 40'd0}, {8'd0, 8'd250, 8'd0, 40'd0}};
    b.in_valid = 1'b0;
    b.in_y = '0;
    b.in_sol = 1'b0;
    b.in_eol = 1'b0;
    b.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("reset_out_valid", b.out_valid, 0);
    chk("reset_out_y", b.out_y, 0);
    chk("reset_out_sol", b.out_sol, 0);
    chk("reset_out_eol", b.out_eol, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("post_reset_in_ready", b.in_ready, 1);
    for (int i = 0; i < 7; i++) begin
      bypass = vecs[i].byp;
      th = vecs[i].th;
      send_line(vecs[i].n, vecs[i].px);
      check_line($sformatf("vec%0d", i), vecs[i].n, vecs[i].ex);
    end
    bypass = 1'b0;
    th = 8'd10;
    fork
      send_line(8, {8{8'd100}});
      begin
        int t = 0;
        while (q.size() < 3 && t < 100) begin
          @(negedge clk);
          t++;
        end
        @(negedge clk);
        b.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #4;
          chk($sformatf("stall%0d_in_ready", k), b.in_ready, 0);
          chk($sformatf("stall%0d_out_valid", k), b.out_valid, 1);
          chk($sformatf("stall%0d_out_y", k), b.out_y, 100);
          chk($sformatf("stall%0d_out_eol", k), b.out_eol, 0);
          @(negedge clk);
        end
        b.out_ready = 1'b1;
      end
    join
    check_line("stall", 8, {8{8'd100}});
    bypass = 1'b1;
    th = 8'd10;
    send_px(8'd100, 1'b1, 1'b0);
    bypass = 1'b0;
    th = 8'd200;
    send_px(8'd140, 1'b0, 1'b0);
    send_px(8'd100, 1'b0, 1'b1);
    chk("flush_in_ready", b.in_ready, 0);
    check_line("latched_byp", 3, {8'd100, 8'd140, 8'd100, 40'd0});
    th = 8'd10;
    send_line(3, {8'd100, 8'd140, 8'd100, 40'd0});
    check_line("next_line_enh", 3, {8'd100, 8'd160, 8'd100, 40'd0});
    send_px(8'd60, 1'b1, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    send_px(8'd60, 1'b0, 1'b0);
    chk("pre_reset_out_valid", b.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", b.out_valid, 0);
    chk("async_reset_out_y", b.out_y, 0);
    chk("async_reset_out_sol", b.out_sol, 0);
    repeat (2) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    #4;
    chk("release_in_ready", b.in_ready, 1);
    send_px(8'd50, 1'b0, 1'b0);
    send_px(8'd50, 1'b0, 1'b1);
    check_line("after_reset", 2, {8'd50, 8'd50, 48'd0});
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
